// File: rtl/vga_ring_pkg.sv
// Shared types and constants for the concentric-pattern VGA engine.
// Imported by the engine top and its centre-bounce sub-module.
package vga_ring_pkg;

    // Pattern metric selected per frame
    typedef enum logic [1:0] {
        MODE_RINGS   = 2'd0,
        MODE_DIAMOND = 2'd1,
        MODE_SQUARE  = 2'd2,
        MODE_XOR     = 2'd3
    } mode_e;

    // Mode-control FSM states
    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_e;

    // Cycles from hpos/vpos input to registered colour output
    localparam int PIPE_LAT = 2;

endpackage

// File: rtl/vga_ring_engine_if.sv
// Video stream interface between the hvsync generator (master) and the
// ring engine (slave): timing in, colour plus delayed syncs out.
interface vga_ring_engine_if #(
    parameter int COLOR_BITS = 2
);
    logic [9:0]            hpos;
    logic [9:0]            vpos;
    logic                  display_on;
    logic                  hsync_in;
    logic                  vsync_in;
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
    logic                  hsync_out;
    logic                  vsync_out;
    logic                  frame_tick;

    modport master (
        output hpos, vpos, display_on, hsync_in, vsync_in,
        input  r, g, b, hsync_out, vsync_out, frame_tick
    );

    modport slave (
        input  hpos, vpos, display_on, hsync_in, vsync_in,
        output r, g, b, hsync_out, vsync_out, frame_tick
    );
endinterface

// File: rtl/vga_ring_center.sv
// Bouncing ring centre: moves BOUNCE_STEP pixels per axis on each step,
// clamping at MARGIN from every edge and reversing direction there.
// Exposes the next-state centre so a frame-start pixel already sees the
// position that holds for the rest of that frame.
module vga_ring_center #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int MARGIN      = 64,
    parameter int BOUNCE_STEP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_i,
    output logic [9:0] cx_nxt_o,
    output logic [9:0] cy_nxt_o
);
    localparam logic signed [11:0] STEP = 12'(BOUNCE_STEP);
    localparam logic signed [11:0] X_LO = 12'(MARGIN);
    localparam logic signed [11:0] X_HI = 12'(H_ACTIVE - MARGIN);
    localparam logic signed [11:0] Y_LO = 12'(MARGIN);
    localparam logic signed [11:0] Y_HI = 12'(V_ACTIVE - MARGIN);

    logic [9:0] cx_q, cy_q, cx_d, cy_d;
    logic       vx_neg_q, vy_neg_q, vx_neg_d, vy_neg_d;

    // One axis of motion: returns {negative_velocity, position}
    function automatic logic [10:0] bounce_axis(
        input logic [9:0]         pos,
        input logic               neg,
        input logic signed [11:0] lo,
        input logic signed [11:0] hi
    );
        logic signed [11:0] sum;
        sum = neg ? ($signed({2'b00, pos}) - STEP) : ($signed({2'b00, pos}) + STEP);
        if (sum >= hi)      return {~neg, 10'(hi)};
        else if (sum <= lo) return {~neg, 10'(lo)};
        else                return {neg, 10'(sum)};
    endfunction

    // Next centre: move on a step, otherwise hold position and heading
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        {vx_neg_d, cx_d} = {vx_neg_q, cx_q};
        {vy_neg_d, cy_d} = {vy_neg_q, cy_q};
        if (step_i) begin
            {vx_neg_d, cx_d} = bounce_axis(cx_q, vx_neg_q, X_LO, X_HI);
            {vy_neg_d, cy_d} = bounce_axis(cy_q, vy_neg_q, Y_LO, Y_HI);
        end
    end

    // Centre and velocity registers; reset to screen middle, moving +x/+y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_q     <= 10'(H_ACTIVE / 2);
            cy_q     <= 10'(V_ACTIVE / 2);
            vx_neg_q <= 1'b0;
            vy_neg_q <= 1'b0;
        end else begin
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            vx_neg_q <= vx_neg_d;
            vy_neg_q <= vy_neg_d;
        end
    end

    assign cx_nxt_o = cx_d;
    assign cy_nxt_o = cy_d;

endmodule

// File: rtl/vga_ring_engine.sv
// Animated concentric-pattern pixel generator (RGB222 by default).
// Sits between the hvsync generator and the pin mapping; colour and syncs
// leave together PIPE_LAT cycles after hpos/vpos arrive. Frame-rate
// controls are sampled at hpos==0 && vpos==0 so a frame never tears.
// Optional build macro VGA_RING_DITHER_EN adds a 2x2 ordered dither.
module vga_ring_engine
    import vga_ring_pkg::*;
#(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int COLOR_BITS   = 2,
    parameter int CYCLE_FRAMES = 256,
    parameter int MARGIN       = 64,
    parameter int BOUNCE_STEP  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vga_ring_engine_if.slave        vid,
    input  logic [2:0]              speed,
    input  logic                    direction,
    input  logic [1:0]              mode_sel,
    input  logic                    auto_cycle,
    input  logic                    bounce_en
);
    localparam int CNT_W = (CYCLE_FRAMES > 2) ? $clog2(CYCLE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE_FRAMES - 1);

    logic frame_start;
    assign frame_start = (vid.hpos == 10'd0) && (vid.vpos == 10'd0);

    // ---------------- frame-rate state ----------------
    logic [9:0]       cx_d, cy_d;
    logic [9:0]       phase_q, phase_d;
    logic             frame_tick_q;
    state_e           state_q;
    mode_e            mode_q;
    logic [CNT_W-1:0] cnt_q;

    vga_ring_center #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .MARGIN      (MARGIN),
        .BOUNCE_STEP (BOUNCE_STEP)
    ) u_center (
        .clk      (clk),
        .rst_n    (rst_n),
        .step_i   (frame_start && bounce_en),
        .cx_nxt_o (cx_d),
        .cy_nxt_o (cy_d)
    );

    // Phase advances by +/-speed once per frame, wrapping naturally
    always_comb begin
        phase_d = phase_q;
        if (frame_start)
            phase_d = direction ? (phase_q - {7'd0, speed}) : (phase_q + {7'd0, speed});
    end

    // Phase and frame-start pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // always_ff samples the pre-edge values of the others.
            phase_q      <= phase_d;
            frame_tick_q <= frame_start;
        end
    end

    // Mode FSM: manual follows mode_sel, auto steps every CYCLE_FRAMES frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_MANUAL;
            mode_q  <= MODE_RINGS;
            cnt_q   <= '0;
        end else if (frame_start) begin
            case (state_q)
                ST_MANUAL: begin
                    mode_q <= mode_e'(mode_sel);
                    cnt_q  <= '0;
                    if (auto_cycle) state_q <= ST_AUTO;
                end
                ST_AUTO: begin
                    if (!auto_cycle) begin
                        state_q <= ST_MANUAL;
                        mode_q  <= mode_e'(mode_sel);
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        mode_q <= mode_e'(mode_q + 2'd1);
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_MANUAL;
            endcase
        end
    end

    // ---------------- pixel pipeline ----------------
    logic [PIPE_LAT-1:0] hs_q, vs_q, de_q;

    // Sync and display-enable delay line matching the colour latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q <= '1;
            vs_q <= '1;
            de_q <= '0;
        end else begin
            hs_q <= {hs_q[PIPE_LAT-2:0], vid.hsync_in};
            vs_q <= {vs_q[PIPE_LAT-2:0], vid.vsync_in};
            de_q <= {de_q[PIPE_LAT-2:0], vid.display_on};
        end
    end

    // Stage 1: signed offsets from the centre and their magnitudes
    logic signed [10:0] dx, dy;
    logic [9:0]         adx, ady;
    logic [9:0]         adx_q, ady_q, axy_q;
    assign dx  = $signed({1'b0, vid.hpos}) - $signed({1'b0, cx_d});
    assign dy  = $signed({1'b0, vid.vpos}) - $signed({1'b0, cy_d});
    assign adx = dx[10] ? 10'(-dx) : dx[9:0];
    assign ady = dy[10] ? 10'(-dy) : dy[9:0];

`ifdef VGA_RING_DITHER_EN
    logic h0_q, v0_q;
`endif

    // Stage-1 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adx_q <= '0;
            ady_q <= '0;
            axy_q <= '0;
`ifdef VGA_RING_DITHER_EN
            h0_q  <= 1'b0;
            v0_q  <= 1'b0;
`endif
        end else begin
            adx_q <= adx;
            ady_q <= ady;
            axy_q <= adx ^ ady;
`ifdef VGA_RING_DITHER_EN
            h0_q  <= vid.hpos[0];
            v0_q  <= vid.vpos[0];
`endif
        end
    end

    // Stage 2: metric, saturation, phase offset (and optional dither)
    logic [9:0]  mx, mn, d;
    logic [10:0] dsum;
    logic [7:0]  a, a_out;
`ifdef VGA_RING_DITHER_EN
    logic [8:0]  a_dith;
`endif
    always_comb begin
        mx = (adx_q > ady_q) ? adx_q : ady_q;
        mn = (adx_q > ady_q) ? ady_q : adx_q;
        case (mode_q)
            MODE_RINGS:   dsum = {1'b0, mx} + {2'b00, mn[9:1]};
            MODE_DIAMOND: dsum = {1'b0, adx_q} + {1'b0, ady_q};
            MODE_SQUARE:  dsum = {1'b0, mx};
            default:      dsum = {1'b0, axy_q};
        endcase
        d = dsum[10] ? 10'h3FF : dsum[9:0];
        a = d[7:0] + phase_q[7:0];
`ifdef VGA_RING_DITHER_EN
        a_dith = {1'b0, a} + {5'd0, h0_q ^ v0_q, v0_q, 2'b00};
        a_out  = a_dith[8] ? 8'hFF : a_dith[7:0];
`else
        a_out  = a;
`endif
    end

    // Low bits that the colour slices never look at
    logic unused_bits;
    assign unused_bits = ^{mn[0], d[9:8], phase_q[9:8], a_out[3:0]};

    logic [COLOR_BITS-1:0] r_q, g_q, b_q;

    // Colour registers, blanked outside active video
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else if (de_q[PIPE_LAT-2]) begin
            r_q <= a_out[5 -: COLOR_BITS];
            g_q <= a_out[6 -: COLOR_BITS];
            b_q <= a_out[7 -: COLOR_BITS];
        end else begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end
    end

    assign vid.r          = r_q;
    assign vid.g          = g_q;
    assign vid.b          = b_q;
    assign vid.hsync_out  = hs_q[PIPE_LAT-1];
    assign vid.vsync_out  = vs_q[PIPE_LAT-1];
    assign vid.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_ring_engine.sv
// Directed self-checking bench for vga_ring_engine (default build, dither off).
// Frames are shortened to two cycles: one frame-start pixel, one blanking pixel.
module tb_vga_ring_engine;

    logic       clk;
    logic       rst_n;
    logic [2:0] speed;
    logic       direction;
    logic [1:0] mode_sel;
    logic       auto_cycle;
    logic       bounce_en;

    int n_cmp = 0;
    int n_bad = 0;

    vga_ring_engine_if #(.COLOR_BITS(2)) vif ();

    vga_ring_engine #(.CYCLE_FRAMES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vid        (vif),
        .speed      (speed),
        .direction  (direction),
        .mode_sel   (mode_sel),
        .auto_cycle (auto_cycle),
        .bounce_en  (bounce_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        vif.hpos       = 10'd700;
        vif.vpos       = 10'd500;
        vif.display_on = 1'b0;
    endtask

    task automatic frame();
        vif.hpos       = 10'd0;
        vif.vpos       = 10'd0;
        vif.display_on = 1'b0;
        tick();
        idle();
        tick();
    endtask

    // Present one pixel, then blanking; afterwards the pixel's colour is visible
    task automatic pixel(input int h, input int v, input logic on);
        vif.hpos       = 10'(h);
        vif.vpos       = 10'(v);
        vif.display_on = on;
        tick();
        idle();
        tick();
    endtask

    function automatic logic [31:0] rgb();
        return 32'({vif.r, vif.g, vif.b});
    endfunction

    initial begin
        rst_n        = 1'b0;
        speed        = 3'd0;
        direction    = 1'b0;
        mode_sel     = 2'd0;
        auto_cycle   = 1'b0;
        bounce_en    = 1'b0;
        vif.hsync_in = 1'b1;
        vif.vsync_in = 1'b1;
        idle();
        tick();
        tick();

        // Reset state
        check("rst_rgb",   rgb(), 32'd0);
        check("rst_hsync", 32'(vif.hsync_out), 32'd1);
        check("rst_vsync", 32'(vif.vsync_out), 32'd1);
        check("rst_tick",  32'(vif.frame_tick), 32'd0);
        check("rst_phase", 32'(dut.phase_q), 32'd0);
        check("rst_mode",  32'(dut.mode_q), 32'd0);
        check("rst_cx",    32'(dut.u_center.cx_q), 32'd320);
        check("rst_cy",    32'(dut.u_center.cy_q), 32'd240);

        // Sync delay: 2 cycles
        rst_n = 1'b1;
        repeat (8) tick();
        vif.hsync_in = 1'b0;
        tick();
        check("hsync_lat1", 32'(vif.hsync_out), 32'd1);
        tick();
        check("hsync_lat2", 32'(vif.hsync_out), 32'd0);
        vif.hsync_in = 1'b1;
        tick();
        tick();
        check("hsync_back", 32'(vif.hsync_out), 32'd1);

        // Blanking and frame_tick
        pixel(400, 290, 1'b0);
        check("blank_rgb", rgb(), 32'd0);
        vif.hpos = 10'd0;
        vif.vpos = 10'd0;
        tick();
        check("tick_hi", 32'(vif.frame_tick), 32'd1);
        idle();
        tick();
        check("tick_lo", 32'(vif.frame_tick), 32'd0);

        // Metrics at phase 0, centre (320,240)
        mode_sel = 2'd0; frame();
        pixel(400, 290, 1'b1);
        check("rings_105", rgb(), 32'b10_11_01);
        mode_sel = 2'd1; frame();
        pixel(400, 290, 1'b1);
        check("diamond_130", rgb(), 32'b00_00_10);
        mode_sel = 2'd2; frame();
        pixel(400, 290, 1'b1);
        check("square_80", rgb(), 32'b01_10_01);
        pixel(240, 240, 1'b1);
        check("square_neg80", rgb(), 32'b01_10_01);
        pixel(336, 240, 1'b1);
        check("square_16", rgb(), 32'b01_00_00);
        mode_sel = 2'd3; frame();
        pixel(400, 256, 1'b1);
        check("xor_64", rgb(), 32'b00_10_01);

        // Phase: +3 x5 then -3 x6 wraps
        mode_sel = 2'd0; speed = 3'd3; direction = 1'b0;
        frame();
        check("phase_3", 32'(dut.phase_q), 32'd3);
        repeat (4) frame();
        check("phase_15", 32'(dut.phase_q), 32'd15);
        direction = 1'b1;
        repeat (6) frame();
        check("phase_1021", 32'(dut.phase_q), 32'd1021);

        // Bring phase to 64: 1021 + 63 + 4 = 1088 -> 64
        direction = 1'b0; speed = 3'd7;
        repeat (9) frame();
        speed = 3'd4;
        frame();
        speed = 3'd0;
        check("phase_64", 32'(dut.phase_q), 32'd64);
        frame();
        pixel(320, 240, 1'b1);
        check("rings_ctr_p64", rgb(), 32'b00_10_01);
        pixel(336, 240, 1'b1);
        check("rings_16_p64", rgb(), 32'b01_10_01);

        // Auto cycle, 4 frames per mode; mode_sel ignored while auto
        auto_cycle = 1'b1; mode_sel = 2'd0;
        frame();
        check("auto_entry", 32'(dut.mode_q), 32'd0);
        mode_sel = 2'd2;
        for (int k = 1; k <= 16; k++) begin
            frame();
            check($sformatf("auto_f%0d", k), 32'(dut.mode_q), 32'((k / 4) % 4));
        end
        auto_cycle = 1'b0;
        frame();
        check("auto_drop", 32'(dut.mode_q), 32'd2);

        // Bounce: centre still home, then 256 frames reaches the right clamp
        check("pre_bounce_cx", 32'(dut.u_center.cx_q), 32'd320);
        bounce_en = 1'b1;
        repeat (255) frame();
        check("cx_575", 32'(dut.u_center.cx_q), 32'd575);
        check("vx_pos", 32'(dut.u_center.vx_neg_q), 32'd0);
        frame();
        check("cx_576", 32'(dut.u_center.cx_q), 32'd576);
        check("vx_neg", 32'(dut.u_center.vx_neg_q), 32'd1);
        check("cy_336", 32'(dut.u_center.cy_q), 32'd336);
        frame();
        check("cx_575_back", 32'(dut.u_center.cx_q), 32'd575);
        bounce_en = 1'b0;
        frame();
        check("cx_hold", 32'(dut.u_center.cx_q), 32'd575);
        check("cy_hold", 32'(dut.u_center.cy_q), 32'd335);
        pixel(591, 335, 1'b1);
        check("moved_ctr_sq", rgb(), 32'b01_10_01);

        // Reset mid-frame clears pipeline at once
        vif.hpos = 10'd591; vif.vpos = 10'd335; vif.display_on = 1'b1;
        vif.hsync_in = 1'b0;
        tick();
        tick();
        check("pre_rst_hs",  32'(vif.hsync_out), 32'd0);
        check("pre_rst_rgb", rgb(), 32'b01_10_01);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_hs",    32'(vif.hsync_out), 32'd1);
        check("mid_rst_rgb",   rgb(), 32'd0);
        check("mid_rst_phase", 32'(dut.phase_q), 32'd0);
        check("mid_rst_cx",    32'(dut.u_center.cx_q), 32'd320);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
